key_debounce: RTL and testbench

Multi-channel push-button front end for the running-light and counter experiments. It synchronises raw active-low board keys and rejects contact bounce with a per-key state machine. Each key produces a clean level, one-cycle press and release pulses, and an auto-repeat step pulse. These outputs drive the en/rst/step inputs of the counter, marquee and display chain, with the board clock as the only clock.

---
 rtl/key_pkg.sv | 23 ++
 rtl/key_debounce_ch.sv | 141 ++++++++++++++
 rtl/key_debounce.sv | 38 +++
 tb/tb_key_debounce.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types and helpers for the multi-channel key debouncer.
// Holds the per-channel state enum and the counter sizing function.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DEB_DN = 2'd1,
    DOWN   = 2'd2,
    DEB_UP = 2'd3
  } key_state_e;

  // Counter width sized so the largest cycle count never wraps.
  function automatic int unsigned cnt_width(input int unsigned deb,
                                            input int unsigned hold,
                                            input int unsigned rep);
    int unsigned m;
    m = deb;
    if (hold > m) m = hold;
    if (rep > m) m = rep;
    return 32'($clog2(m)) + 32'd1;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// Single key channel: 2-flop synchroniser, debounce FSM, hold/auto-repeat counter.
// All outputs are registered; en low forces the channel back to IDLE.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int unsigned DEB_CYC  = 1_000_000,
  parameter int unsigned HOLD_CYC = 25_000_000,
  parameter int unsigned REP_CYC  = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic key_n,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_step
);

  localparam int unsigned   CW          = cnt_width(DEB_CYC, HOLD_CYC, REP_CYC);
  localparam logic [CW-1:0] ONE         = CW'(1);
  localparam logic [CW-1:0] DEB_LAST    = CW'(DEB_CYC - 32'd1);
  localparam bit            REP_EN      = (HOLD_CYC != 32'd0);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYC - 32'd1);
  // Modular reload: distance to HOLD_LAST is always REP_CYC-1 counts.
  localparam logic [CW-1:0] HOLD_RELOAD = CW'(HOLD_CYC - REP_CYC);

  logic [1:0]    sync_q;
  logic          key_s;
  key_state_e    state_q, state_d;
  logic [CW-1:0] dcnt_q, dcnt_d;
  logic [CW-1:0] hcnt_q, hcnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          step_q, step_d;

  assign key_s = sync_q[1];

  // Synchroniser keeps running regardless of en.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], ~key_n};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      dcnt_q    <= '0;
      hcnt_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dcnt_q    <= dcnt_d;
      hcnt_q    <= hcnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      step_q    <= step_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    hcnt_d    = hcnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    step_d    = 1'b0;

    if (!en) begin
      state_d = IDLE;
      dcnt_d  = '0;
      hcnt_d  = '0;
      level_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (key_s) begin
            state_d = DEB_DN;
            dcnt_d  = '0;
          end
        end
        DEB_DN: begin
          if (!key_s) begin
            state_d = IDLE;
          end else if (dcnt_q == DEB_LAST) begin
            state_d = DOWN;
            press_d = 1'b1;
            step_d  = 1'b1;
            level_d = 1'b1;
            hcnt_d  = '0;
          end else begin
            dcnt_d = dcnt_q + ONE;
          end
        end
        DOWN: begin
          // Hold counter freezes while the release is being debounced.
          if (!key_s) begin
            state_d = DEB_UP;
            dcnt_d  = '0;
          end else if (REP_EN) begin
            if (hcnt_q == HOLD_LAST) begin
              step_d = 1'b1;
              hcnt_d = HOLD_RELOAD;
            end else begin
              hcnt_d = hcnt_q + ONE;
            end
          end
        end
        DEB_UP: begin
          if (key_s) begin
            state_d = DOWN;
          end else if (dcnt_q == DEB_LAST) begin
            state_d   = IDLE;
            release_d = 1'b1;
            level_d   = 1'b0;
          end else begin
            dcnt_d = dcnt_q + ONE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_step    = step_q;

endmodule

// File: rtl/key_debounce.sv
// Multi-channel push-button front end: NKEY independent debounce channels
// sharing clock, reset and the global enable.
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned NKEY     = 4,
  parameter int unsigned DEB_CYC  = 1_000_000,
  parameter int unsigned HOLD_CYC = 25_000_000,
  parameter int unsigned REP_CYC  = 5_000_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [NKEY-1:0] key_n,
  output logic [NKEY-1:0] key_level,
  output logic [NKEY-1:0] key_press,
  output logic [NKEY-1:0] key_release,
  output logic [NKEY-1:0] key_step
);

  for (genvar g = 0; g < NKEY; g++) begin : g_ch
    key_debounce_ch #(
      .DEB_CYC (DEB_CYC),
      .HOLD_CYC(HOLD_CYC),
      .REP_CYC (REP_CYC)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .key_n      (key_n[g]),
      .key_level  (key_level[g]),
      .key_press  (key_press[g]),
      .key_release(key_release[g]),
      .key_step   (key_step[g])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: expected pulse events are queued when
// stimulus is driven and matched against pulses logged from the DUT.
`timescale 1ns/1ps
module tb_key_debounce;

  localparam int unsigned NKEY = 4;
  localparam int unsigned DEB  = 8;
  localparam int unsigned HOLD = 32;
  localparam int unsigned REP  = 8;

  typedef struct packed {
    logic [31:0] cyc;
    logic [3:0]  press;
    logic [3:0]  rel;
    logic [3:0]  step;
  } ev_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [NKEY-1:0] key_n;
  logic [NKEY-1:0] key_level;
  logic [NKEY-1:0] key_press;
  logic [NKEY-1:0] key_release;
  logic [NKEY-1:0] key_step;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  ev_t         exp_q[$];
  ev_t         obs_q[$];

  key_debounce #(
    .NKEY(NKEY), .DEB_CYC(DEB), .HOLD_CYC(HOLD), .REP_CYC(REP)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .key_n(key_n),
    .key_level(key_level), .key_press(key_press),
    .key_release(key_release), .key_step(key_step)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Log every pulse cycle, tagged with the number of rising edges so far.
  always @(negedge clk) begin
    if (rst && ((key_press | key_release | key_step) != 4'b0000))
      obs_q.push_back({cyc, key_press, key_release, key_step});
  end

  function automatic void expect_ev(input int unsigned c, input logic [3:0] p,
                                    input logic [3:0] r, input logic [3:0] s);
    exp_q.push_back({c, p, r, s});
  endfunction

  task automatic wait_until(input int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b1; key_n = 4'hF;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({key_level, key_press, key_release, key_step} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_assert: got %h, expected 0000", {key_level, key_press, key_release, key_step});
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({key_level, key_press, key_release, key_step} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_release: got %h, expected 0000", {key_level, key_press, key_release, key_step});
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL reset_idle: got %0d events, expected 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_clean_press;
    int unsigned c;
    ev_t e, o;
    c = cyc;
    key_n[0] = 1'b0;
    expect_ev(c + 11, 4'b0001, 4'b0000, 4'b0001);
    wait_until(c + 15);
    checks++;
    if (key_level !== 4'b0001) begin
      errors++; $display("FAIL clean_level_held: got %b, expected 0001", key_level);
    end
    wait_until(c + 20);
    key_n[0] = 1'b1;
    expect_ev(c + 31, 4'b0000, 4'b0001, 4'b0000);
    wait_until(c + 31);
    checks++;
    if (key_level !== 4'b0000) begin
      errors++; $display("FAIL clean_level_released: got %b, expected 0000", key_level);
    end
    wait_until(c + 60);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL clean_press missing: got none, expected cyc=%0d press=%b rel=%b step=%b", e.cyc, e.press, e.rel, e.step);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL clean_press event: got cyc=%0d press=%b rel=%b step=%b, expected cyc=%0d press=%b rel=%b step=%b",
                   o.cyc, o.press, o.rel, o.step, e.cyc, e.press, e.rel, e.step);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL clean_press extra: got %0d events (first cyc=%0d), expected 0", obs_q.size(), obs_q[0].cyc);
      obs_q.delete();
    end
  endtask

  task automatic test_bounce;
    int unsigned f;
    ev_t e, o;
    for (int i = 0; i < 3; i++) begin
      key_n[1] = 1'b0;
      repeat (3) @(negedge clk);
      key_n[1] = 1'b1;
      repeat (3) @(negedge clk);
    end
    checks++;
    if (key_level !== 4'b0000) begin
      errors++; $display("FAIL bounce_level: got %b, expected 0000", key_level);
    end
    f = cyc;
    key_n[1] = 1'b0;
    expect_ev(f + 11, 4'b0010, 4'b0000, 4'b0010);
    wait_until(f + 20);
    key_n[1] = 1'b1;
    expect_ev(f + 31, 4'b0000, 4'b0010, 4'b0000);
    wait_until(f + 40);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL bounce missing: got none, expected cyc=%0d press=%b rel=%b step=%b", e.cyc, e.press, e.rel, e.step);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL bounce event: got cyc=%0d press=%b rel=%b step=%b, expected cyc=%0d press=%b rel=%b step=%b",
                   o.cyc, o.press, o.rel, o.step, e.cyc, e.press, e.rel, e.step);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL bounce extra: got %0d events (first cyc=%0d), expected 0", obs_q.size(), obs_q[0].cyc);
      obs_q.delete();
    end
  endtask

  task automatic test_long_hold;
    int unsigned c, p;
    ev_t e, o;
    c = cyc;
    p = c + 11;
    key_n[2] = 1'b0;
    expect_ev(p, 4'b0100, 4'b0000, 4'b0100);
    for (int unsigned k = HOLD; k <= 72; k += REP)
      expect_ev(p + k, 4'b0000, 4'b0000, 4'b0100);
    wait_until(p + 76);
    key_n[2] = 1'b1;
    expect_ev(p + 87, 4'b0000, 4'b0100, 4'b0000);
    wait_until(p + 100);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL long_hold missing: got none, expected cyc=%0d press=%b rel=%b step=%b", e.cyc, e.press, e.rel, e.step);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL long_hold event: got cyc=%0d press=%b rel=%b step=%b, expected cyc=%0d press=%b rel=%b step=%b",
                   o.cyc, o.press, o.rel, o.step, e.cyc, e.press, e.rel, e.step);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL long_hold extra: got %0d events (first cyc=%0d), expected 0", obs_q.size(), obs_q[0].cyc);
      obs_q.delete();
    end
  endtask

  task automatic test_simultaneous;
    int unsigned c;
    ev_t e, o;
    c = cyc;
    key_n = 4'b0110;
    expect_ev(c + 11, 4'b1001, 4'b0000, 4'b1001);
    wait_until(c + 20);
    key_n = 4'b1111;
    expect_ev(c + 31, 4'b0000, 4'b1001, 4'b0000);
    wait_until(c + 40);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL simultaneous missing: got none, expected cyc=%0d press=%b rel=%b step=%b", e.cyc, e.press, e.rel, e.step);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL simultaneous event: got cyc=%0d press=%b rel=%b step=%b, expected cyc=%0d press=%b rel=%b step=%b",
                   o.cyc, o.press, o.rel, o.step, e.cyc, e.press, e.rel, e.step);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL simultaneous extra: got %0d events (first cyc=%0d), expected 0", obs_q.size(), obs_q[0].cyc);
      obs_q.delete();
    end
  endtask

  task automatic test_en_drop;
    int unsigned c, r;
    ev_t e, o;
    c = cyc;
    key_n[0] = 1'b0;
    expect_ev(c + 11, 4'b0001, 4'b0000, 4'b0001);
    wait_until(c + 15);
    checks++;
    if (key_level !== 4'b0001) begin
      errors++; $display("FAIL en_level_before: got %b, expected 0001", key_level);
    end
    en = 1'b0;
    wait_until(c + 16);
    checks++;
    if (key_level !== 4'b0000) begin
      errors++; $display("FAIL en_level_dropped: got %b, expected 0000", key_level);
    end
    wait_until(c + 20);
    r = cyc;
    en = 1'b1;
    expect_ev(r + 9, 4'b0001, 4'b0000, 4'b0001);
    wait_until(r + 15);
    key_n[0] = 1'b1;
    expect_ev(r + 26, 4'b0000, 4'b0001, 4'b0000);
    wait_until(r + 35);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL en_drop missing: got none, expected cyc=%0d press=%b rel=%b step=%b", e.cyc, e.press, e.rel, e.step);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL en_drop event: got cyc=%0d press=%b rel=%b step=%b, expected cyc=%0d press=%b rel=%b step=%b",
                   o.cyc, o.press, o.rel, o.step, e.cyc, e.press, e.rel, e.step);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL en_drop extra: got %0d events (first cyc=%0d), expected 0", obs_q.size(), obs_q[0].cyc);
      obs_q.delete();
    end
  endtask

  task automatic test_reset_mid;
    int unsigned c, r;
    ev_t e, o;
    c = cyc;
    key_n[1] = 1'b0;
    wait_until(c + 6);
    rst = 1'b0;
    #1;
    checks++;
    if ({key_level, key_press, key_release, key_step} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid_assert: got %h, expected 0000", {key_level, key_press, key_release, key_step});
    end
    repeat (2) @(negedge clk);
    r = cyc;
    rst = 1'b1;
    expect_ev(r + 11, 4'b0010, 4'b0000, 4'b0010);
    wait_until(r + 20);
    key_n[1] = 1'b1;
    expect_ev(r + 31, 4'b0000, 4'b0010, 4'b0000);
    wait_until(r + 40);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL reset_mid missing: got none, expected cyc=%0d press=%b rel=%b step=%b", e.cyc, e.press, e.rel, e.step);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL reset_mid event: got cyc=%0d press=%b rel=%b step=%b, expected cyc=%0d press=%b rel=%b step=%b",
                   o.cyc, o.press, o.rel, o.step, e.cyc, e.press, e.rel, e.step);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid extra: got %0d events (first cyc=%0d), expected 0", obs_q.size(), obs_q[0].cyc);
      obs_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_hold();
    test_simultaneous();
    test_en_drop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
